flash_seq_ctrl: RTL and testbench
=================================

Name: flash_seq_ctrl

Overview:
- Sequencer for the SPI flash controller (flash_contorl).
- On one start pulse it runs a full self-test:
  - read JEDEC ID
  - write-enable, sector erase
  - write-enable, page program of a seeded byte pattern
  - read-back of the page with on-the-fly compare
- Reports busy, done, pass/fail and mismatch count for display (e.g. segdisplay).
- Replaces ad-hoc request decoding in top-level files.

Parameters:
- PAGE_BYTES, 256, bytes programmed and read back (1..256).
- EXPECT_ID, 24'hEF4017, JEDEC ID required to continue past ID read.
- SECTOR_ADDR, 24'h000000, erase address; read address = SECTOR_ADDR.
- PAGE_IDX, 16'd0, page index passed to write_page; must lie inside SECTOR_ADDR's sector.

Ports:
- sys_clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- start  in  1  one-cycle pulse; begins sequence when idle
- seed  in  8  pattern seed, sampled on accepted start
- read_id_req  out  1  level request to flash controller
- read_id_end  in  1  one-cycle completion pulse
- flash_id  in  24  ID returned by controller
- write_enable_req  out  1  level request
- write_enable_end  in  1  completion pulse
- erase_sector_req  out  1  level request
- erase_sector_addr  out  24  = SECTOR_ADDR
- erase_sector_end  in  1  completion pulse
- write_req  out  1  level request
- write_page  out  16  = PAGE_IDX
- write_size  out  10  = PAGE_BYTES
- write_data  out  8  current byte to program
- write_ack  in  1  byte consumed; advance write_data
- write_end  in  1  completion pulse
- read_req  out  1  level request
- read_addr  out  24  = SECTOR_ADDR
- read_size  out  10  = PAGE_BYTES
- read_data  in  8  read byte, valid with read_ack
- read_ack  in  1  read byte valid
- read_end  in  1  completion pulse
- busy  out  1  sequence in progress
- done  out  1  one-cycle pulse at sequence end
- pass  out  1  held result of last sequence
- id_err  out  1  held; last ID mismatched EXPECT_ID
- err_cnt  out  9  held mismatch count of last sequence (0..256)
- id_out  out  24  held ID captured in last sequence

Behaviour:
- States: S_IDLE, S_RDID, S_WEN1, S_ERASE, S_WEN2, S_PROG, S_READ, S_DONE (one-hot).
- All outputs registered. Reset values:
  - all requests, busy, done, pass, id_err = 0
  - err_cnt = 0, id_out = 0, write_data = 0
  - state = S_IDLE
- Reset mid-operation drops every request immediately (async); no cleanup command is issued.
- S_IDLE:
  - start=1 -> latch seed, set write_data=seed, clear err_cnt, set busy=1, go S_RDID next cycle.
  - start is ignored while busy.
- Each work state asserts exactly one *_req, held high from the first cycle in the state until its *_end pulse is seen.
  - The request is low the cycle after *_end and the next state's request rises that same cycle.
  - No two requests are ever high together.
- Transitions:
  - S_RDID on read_id_end:
    - capture id_out=flash_id.
    - If flash_id != EXPECT_ID -> id_err=1, go S_DONE.
    - Otherwise id_err=0, go S_WEN1.
  - S_WEN1 -> S_ERASE -> S_WEN2 -> S_PROG -> S_READ -> S_DONE, each on its *_end pulse.
- S_PROG: each write_ack advances write_data by 1 (mod 256). Byte n programmed = seed+n.
- S_READ:
  - rd_idx starts at 0.
  - On each read_ack, compare read_data with (seed+rd_idx) mod 256; a mismatch increments err_cnt; rd_idx increments.
  - read_ack in the same cycle as read_end is still compared.
- S_DONE (one cycle): done=1, busy=0, pass = !id_err && err_cnt==0 && rd_idx==PAGE_BYTES; then S_IDLE.
- Short read (rd_idx < PAGE_BYTES at read_end): pass=0; err_cnt counts only actual mismatches.
- Acks and end pulses arriving outside their matching state are ignored.

Optional Feature:
- FLASH_SEQ_TIMEOUT_EN defined:
  - 24-bit per-state watchdog, reloaded on each state entry.
  - If no *_end arrives within 2^24 sys_clk cycles, the request drops, timeout output (1 bit, held, reset 0) is set, and the block goes to S_DONE with pass=0.
- Undefined: no watchdog and no timeout port; the block waits indefinitely.

Decomposition:
- Package flash_seq_pkg holds:
  - state encoding localparams
  - JEDEC ID constant
  - page/sector size constants shared with flash_contorl
- One sub-module, flash_seq_cmp: pattern generator plus comparator (seed, rd_idx, err_cnt).
- The FSM stays in flash_seq_ctrl.

Test Plan:
- Bench: flash_contorl behavioural model with 4-cycle end latency.
- Nominal run: seed=8'hBC, model stores written bytes, returns ID EF4017 -> request order RDID, WEN, ERASE, WEN, PROG, READ; 256 write_acks with data BC..BB; done pulse; pass=1, err_cnt=0.
- ID mismatch: model returns 24'h000000 -> id_err=1, pass=0, no write_enable_req ever asserted, done 1 cycle after read_id_end.
- Corrupted read-back: model flips bytes 0, 17, 255 -> err_cnt=3, pass=0.
- Short read: model raises read_end after 200 acks, all correct -> pass=0, err_cnt=0.
- Start while busy and reset mid-erase:
  - second start in S_PROG is ignored.
  - rst pulsed in S_ERASE -> erase_sector_req low immediately, busy=0.
  - a new start afterwards runs a clean full sequence.

Source files
------------

// File: rtl/flash_seq_pkg.sv
// flash_seq_pkg: state encoding and constants shared by the flash self-test
// sequencer and the flash_contorl command interface.
package flash_seq_pkg;

    localparam int I_IDLE  = 0;
    localparam int I_RDID  = 1;
    localparam int I_WEN1  = 2;
    localparam int I_ERASE = 3;
    localparam int I_WEN2  = 4;
    localparam int I_PROG  = 5;
    localparam int I_READ  = 6;
    localparam int I_DONE  = 7;

    localparam logic [7:0] S_IDLE  = 8'h01;
    localparam logic [7:0] S_RDID  = 8'h02;
    localparam logic [7:0] S_WEN1  = 8'h04;
    localparam logic [7:0] S_ERASE = 8'h08;
    localparam logic [7:0] S_WEN2  = 8'h10;
    localparam logic [7:0] S_PROG  = 8'h20;
    localparam logic [7:0] S_READ  = 8'h40;
    localparam logic [7:0] S_DONE  = 8'h80;

    localparam logic [23:0] JEDEC_ID = 24'hEF4017;

    localparam int PAGE_SIZE   = 256;
    localparam int SECTOR_SIZE = 4096;
    localparam int WD_BITS     = 24;

    // Byte n of the test pattern is seed+n, wrapping at 256.
    function automatic logic [7:0] pat_byte(
        input logic [7:0] seed,
        input logic [9:0] idx
    );
        return seed + idx[7:0];
    endfunction

endpackage

// File: rtl/flash_seq_cmp.sv
// flash_seq_cmp: seeded pattern generator for programming and
// on-the-fly comparator for read-back.
module flash_seq_cmp
    import flash_seq_pkg::*;
(
    input  logic       sys_clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] seed,
    input  logic       wr_adv,
    input  logic       rd_chk,
    input  logic [7:0] rd_byte,
    output logic [7:0] write_data,
    output logic [8:0] err_cnt,
    output logic [8:0] err_nxt,
    output logic [9:0] idx_nxt
);

    logic [7:0] seed_q;
    logic [9:0] rd_idx;
    logic       miss;

    // Counters saturate so a runaway ack stream can never wrap to a pass.
    always_comb begin
        miss    = rd_chk && (rd_byte != pat_byte(seed_q, rd_idx));
        err_nxt = err_cnt;
        idx_nxt = rd_idx;
        if (miss && err_cnt != '1)
            err_nxt = err_cnt + 9'd1;
        if (rd_chk && rd_idx != '1)
            idx_nxt = rd_idx + 10'd1;
    end

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            seed_q     <= '0;
            write_data <= '0;
            err_cnt    <= '0;
            rd_idx     <= '0;
        end else if (load) begin
            seed_q     <= seed;
            write_data <= seed;
            err_cnt    <= '0;
            rd_idx     <= '0;
        end else begin
            if (wr_adv)
                write_data <= write_data + 8'd1;
            err_cnt <= err_nxt;
            rd_idx  <= idx_nxt;
        end
    end

endmodule

// File: rtl/flash_seq_ctrl.sv
// flash_seq_ctrl: one-shot SPI flash self-test (ID, erase, program, verify).
// Define FLASH_SEQ_TIMEOUT_EN for a per-state watchdog and timeout output.
module flash_seq_ctrl
    import flash_seq_pkg::*;
#(
    parameter int          PAGE_BYTES  = PAGE_SIZE,
    parameter logic [23:0] EXPECT_ID   = JEDEC_ID,
    parameter logic [23:0] SECTOR_ADDR = 24'h000000,
    parameter logic [15:0] PAGE_IDX    = 16'd0
) (
    input  logic        sys_clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  seed,
    output logic        read_id_req,
    input  logic        read_id_end,
    input  logic [23:0] flash_id,
    output logic        write_enable_req,
    input  logic        write_enable_end,
    output logic        erase_sector_req,
    output logic [23:0] erase_sector_addr,
    input  logic        erase_sector_end,
    output logic        write_req,
    output logic [15:0] write_page,
    output logic [9:0]  write_size,
    output logic [7:0]  write_data,
    input  logic        write_ack,
    input  logic        write_end,
    output logic        read_req,
    output logic [23:0] read_addr,
    output logic [9:0]  read_size,
    input  logic [7:0]  read_data,
    input  logic        read_ack,
    input  logic        read_end,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic        id_err,
    output logic [8:0]  err_cnt,
`ifdef FLASH_SEQ_TIMEOUT_EN
    output logic        timeout,
`endif
    output logic [23:0] id_out
);

    logic [7:0] state;
    logic       load;
    logic       wr_adv;
    logic       rd_chk;
    logic       seq_ok;
    logic [8:0] err_nxt;
    logic [9:0] idx_nxt;

    assign erase_sector_addr = SECTOR_ADDR;
    assign write_page        = PAGE_IDX;
    assign write_size        = 10'(PAGE_BYTES);
    assign read_addr         = SECTOR_ADDR;
    assign read_size         = 10'(PAGE_BYTES);

    assign load   = state[I_IDLE] & start;
    assign wr_adv = state[I_PROG] & write_ack;
    assign rd_chk = state[I_READ] & read_ack;

    // Uses next-cycle counts so an ack coincident with read_end is counted.
    assign seq_ok = !id_err && (err_nxt == '0)
                    && (idx_nxt == 10'(PAGE_BYTES));

    flash_seq_cmp u_cmp (
        .sys_clk    (sys_clk),
        .rst        (rst),
        .load       (load),
        .seed       (seed),
        .wr_adv     (wr_adv),
        .rd_chk     (rd_chk),
        .rd_byte    (read_data),
        .write_data (write_data),
        .err_cnt    (err_cnt),
        .err_nxt    (err_nxt),
        .idx_nxt    (idx_nxt)
    );

`ifdef FLASH_SEQ_TIMEOUT_EN
    logic [WD_BITS-1:0] wd_cnt;
    logic [7:0]         wd_state;
    logic               work;
    logic               cur_end;
    logic               wd_fire;

    always_comb begin
        cur_end = 1'b0;
        unique case (1'b1)
            state[I_RDID]:  cur_end = read_id_end;
            state[I_WEN1]:  cur_end = write_enable_end;
            state[I_ERASE]: cur_end = erase_sector_end;
            state[I_WEN2]:  cur_end = write_enable_end;
            state[I_PROG]:  cur_end = write_end;
            state[I_READ]:  cur_end = read_end;
            default:        cur_end = 1'b0;
        endcase
    end

    assign work    = !(state[I_IDLE] | state[I_DONE]);
    assign wd_fire = work && (wd_state == state)
                     && (&wd_cnt) && !cur_end;

    // A state change is seen one cycle late; that cycle clears the count.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            wd_cnt   <= '0;
            wd_state <= S_IDLE;
        end else begin
            wd_state <= state;
            if (wd_state != state)
                wd_cnt <= '0;
            else if (work)
                wd_cnt <= wd_cnt + 1'b1;
        end
    end
`endif

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            state            <= S_IDLE;
            read_id_req      <= 1'b0;
            write_enable_req <= 1'b0;
            erase_sector_req <= 1'b0;
            write_req        <= 1'b0;
            read_req         <= 1'b0;
            busy             <= 1'b0;
            done             <= 1'b0;
            pass             <= 1'b0;
            id_err           <= 1'b0;
            id_out           <= '0;
`ifdef FLASH_SEQ_TIMEOUT_EN
            timeout          <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            unique case (1'b1)
                state[I_IDLE]: begin
                    if (start) begin
                        busy        <= 1'b1;
                        read_id_req <= 1'b1;
                        state       <= S_RDID;
                    end
                end
                state[I_RDID]: begin
                    if (read_id_end) begin
                        read_id_req <= 1'b0;
                        id_out      <= flash_id;
                        if (flash_id != EXPECT_ID) begin
                            id_err <= 1'b1;
                            pass   <= 1'b0;
                            done   <= 1'b1;
                            busy   <= 1'b0;
                            state  <= S_DONE;
                        end else begin
                            id_err           <= 1'b0;
                            write_enable_req <= 1'b1;
                            state            <= S_WEN1;
                        end
                    end
                end
                state[I_WEN1]: begin
                    if (write_enable_end) begin
                        write_enable_req <= 1'b0;
                        erase_sector_req <= 1'b1;
                        state            <= S_ERASE;
                    end
                end
                state[I_ERASE]: begin
                    if (erase_sector_end) begin
                        erase_sector_req <= 1'b0;
                        write_enable_req <= 1'b1;
                        state            <= S_WEN2;
                    end
                end
                state[I_WEN2]: begin
                    if (write_enable_end) begin
                        write_enable_req <= 1'b0;
                        write_req        <= 1'b1;
                        state            <= S_PROG;
                    end
                end
                state[I_PROG]: begin
                    if (write_end) begin
                        write_req <= 1'b0;
                        read_req  <= 1'b1;
                        state     <= S_READ;
                    end
                end
                state[I_READ]: begin
                    if (read_end) begin
                        read_req <= 1'b0;
                        pass     <= seq_ok;
                        done     <= 1'b1;
                        busy     <= 1'b0;
                        state    <= S_DONE;
                    end
                end
                state[I_DONE]: state <= S_IDLE;
                default:       state <= S_IDLE;
            endcase
`ifdef FLASH_SEQ_TIMEOUT_EN
            if (load)
                timeout <= 1'b0;
            if (wd_fire) begin
                read_id_req      <= 1'b0;
                write_enable_req <= 1'b0;
                erase_sector_req <= 1'b0;
                write_req        <= 1'b0;
                read_req         <= 1'b0;
                pass             <= 1'b0;
                done             <= 1'b1;
                busy             <= 1'b0;
                timeout          <= 1'b1;
                state            <= S_DONE;
            end
`endif
        end
    end

endmodule

// File: tb/tb_flash_seq_ctrl.sv
// tb_flash_seq_ctrl: flash_contorl behavioural model with 4-cycle end
// latency, randomized ack timing and seeds, checked against a pattern model.
module tb_flash_seq_ctrl;

    localparam int          PB     = 256;
    localparam logic [23:0] EXP_ID = 24'hEF4017;

    logic        sys_clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  seed;
    logic        read_id_req;
    logic        read_id_end;
    logic [23:0] flash_id;
    logic        write_enable_req;
    logic        write_enable_end;
    logic        erase_sector_req;
    logic [23:0] erase_sector_addr;
    logic        erase_sector_end;
    logic        write_req;
    logic [15:0] write_page;
    logic [9:0]  write_size;
    logic [7:0]  write_data;
    logic        write_ack;
    logic        write_end;
    logic        read_req;
    logic [23:0] read_addr;
    logic [9:0]  read_size;
    logic [7:0]  read_data;
    logic        read_ack;
    logic        read_end;
    logic        busy;
    logic        done;
    logic        pass;
    logic        id_err;
    logic [8:0]  err_cnt;
    logic [23:0] id_out;

    logic [4:0]  reqv;
    logic [7:0]  mem [PB];
    int          n_chk = 0;
    int          n_fail = 0;
    int          hot_viol = 0;
    int          wen_cyc = 0;

    always #5 sys_clk = ~sys_clk;

    assign reqv = {read_req, write_req, erase_sector_req,
                   write_enable_req, read_id_req};

    flash_seq_ctrl dut (
        .sys_clk           (sys_clk),
        .rst               (rst),
        .start             (start),
        .seed              (seed),
        .read_id_req       (read_id_req),
        .read_id_end       (read_id_end),
        .flash_id          (flash_id),
        .write_enable_req  (write_enable_req),
        .write_enable_end  (write_enable_end),
        .erase_sector_req  (erase_sector_req),
        .erase_sector_addr (erase_sector_addr),
        .erase_sector_end  (erase_sector_end),
        .write_req         (write_req),
        .write_page        (write_page),
        .write_size        (write_size),
        .write_data        (write_data),
        .write_ack         (write_ack),
        .write_end         (write_end),
        .read_req          (read_req),
        .read_addr         (read_addr),
        .read_size         (read_size),
        .read_data         (read_data),
        .read_ack          (read_ack),
        .read_end          (read_end),
        .busy              (busy),
        .done              (done),
        .pass              (pass),
        .id_err            (id_err),
        .err_cnt           (err_cnt),
        .id_out            (id_out)
    );

    always @(negedge sys_clk) begin
        if ($countones(reqv) > 1)
            hot_viol++;
        if (write_enable_req)
            wen_cyc++;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic set_end(input int i, input logic v);
        case (i)
            0:       read_id_end      = v;
            1:       write_enable_end = v;
            2:       erase_sector_end = v;
            3:       write_end        = v;
            default: read_end         = v;
        endcase
    endtask

    task automatic wait_req(output logic [4:0] got, output int waited);
        waited = 0;
        while (reqv == '0 && waited < 20) begin
            tick();
            waited++;
        end
        got = reqv;
    endtask

    // Stray end pulse and acks that do not belong to the current request.
    task automatic noise(input logic [4:0] cur);
        int i;
        do i = $urandom_range(0, 4); while (cur[i]);
        set_end(i, 1'b1);
        write_ack = 1'b1;
        read_ack  = 1'b1;
        read_data = 8'($urandom);
        tick();
        set_end(i, 1'b0);
        write_ack = 1'b0;
        read_ack  = 1'b0;
    endtask

    task automatic simple(input int i, input logic [4:0] cur,
                          input logic [23:0] id);
        tick();
        noise(cur);
        tick();
        chk("req_held", reqv, cur);
        if (i == 0) flash_id = id;
        if (i == 2) foreach (mem[j]) mem[j] = 8'hFF;
        set_end(i, 1'b1);
        tick();
        set_end(i, 1'b0);
        flash_id = 24'($urandom);
    endtask

    task automatic run_seq(input logic [7:0] sd, input logic [23:0] id,
                           input int n_rd, input bit corrupt,
                           input bit same_end, input bit busy_start,
                           input bit abort_erase);
        logic [4:0] ord [6];
        int         idx [6];
        int         nsteps, waited, k, cyc, wr_bad, exp_err, wen0;
        logic [4:0] got;
        logic [7:0] b, e;
        logic       exp_pass;
        ord     = '{5'h01, 5'h02, 5'h04, 5'h02, 5'h08, 5'h10};
        idx     = '{0, 1, 2, 1, 3, 4};
        nsteps  = (id == EXP_ID) ? 6 : 1;
        wr_bad  = 0;
        exp_err = 0;
        k       = 0;
        wen0    = wen_cyc;
        seed    = sd;
        start   = 1'b1;
        tick();
        start = 1'b0;
        seed  = 8'($urandom);
        chk("busy", busy, 1);
        for (int s = 0; s < nsteps; s++) begin
            wait_req(got, waited);
            chk("req_order", got, ord[s]);
            chk("req_lat", waited, 0);
            if (abort_erase && s == 2) begin
                tick();
                tick();
                rst = 1'b1;
                #1;
                chk("rst_erase_req", erase_sector_req, 0);
                chk("rst_busy", busy, 0);
                tick();
                rst = 1'b0;
                tick();
                chk("rst_reqs", reqv, 0);
                chk("rst_id_out", id_out, 0);
                chk("rst_wdata", write_data, 0);
                return;
            end
            if (s == 4) begin
                tick();
                tick();
                cyc = 0;
                k   = 0;
                while (k < PB && cyc < 3000) begin
                    if ($urandom_range(0, 3) != 0) begin
                        e = sd + 8'(k);
                        if (write_data !== e) wr_bad++;
                        mem[k]    = write_data;
                        write_ack = 1'b1;
                        k++;
                    end else begin
                        write_ack = 1'b0;
                    end
                    start = (busy_start && k == 100);
                    tick();
                    cyc++;
                end
                write_ack = 1'b0;
                start     = 1'b0;
                chk("wr_acks", k, PB);
                chk("wr_bytes", wr_bad, 0);
                chk("busy_prog", busy, 1);
                tick();
                tick();
                tick();
                write_end = 1'b1;
                tick();
                write_end = 1'b0;
            end else if (s == 5) begin
                tick();
                tick();
                cyc = 0;
                k   = 0;
                while (k < n_rd && cyc < 3000) begin
                    if ($urandom_range(0, 2) != 0) begin
                        b = mem[k];
                        if (corrupt && (k == 0 || k == 17 || k == 255))
                            b = b ^ 8'h5A;
                        e = sd + 8'(k);
                        if (b != e) exp_err++;
                        read_data = b;
                        read_ack  = 1'b1;
                        k++;
                        if (k == n_rd && same_end) read_end = 1'b1;
                    end else begin
                        read_ack  = 1'b0;
                        read_data = 8'($urandom);
                    end
                    tick();
                    cyc++;
                end
                read_ack = 1'b0;
                if (!same_end) begin
                    tick();
                    tick();
                    tick();
                    read_end = 1'b1;
                    tick();
                end
                read_end = 1'b0;
            end else begin
                simple(idx[s], ord[s], id);
            end
        end
        exp_pass = (id == EXP_ID) && (exp_err == 0) && (k == PB);
        chk("done", done, 1);
        chk("busy_done", busy, 0);
        chk("pass", pass, exp_pass);
        chk("err_cnt", err_cnt, exp_err);
        chk("id_out", id_out, id);
        chk("id_err", id_err, id != EXP_ID);
        tick();
        chk("done_pulse", done, 0);
        chk("pass_hold", pass, exp_pass);
        tick();
        tick();
        chk("idle_reqs", reqv, 0);
        if (id != EXP_ID)
            chk("no_wen", wen_cyc - wen0, 0);
    endtask

    initial begin
        start            = 1'b0;
        seed             = '0;
        flash_id         = '0;
        read_id_end      = 1'b0;
        write_enable_end = 1'b0;
        erase_sector_end = 1'b0;
        write_ack        = 1'b0;
        write_end        = 1'b0;
        read_data        = '0;
        read_ack         = 1'b0;
        read_end         = 1'b0;
        rst              = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("rst_reqs0", reqv, 0);
        chk("rst_flags0", {busy, done, pass, id_err}, 0);
        chk("rst_err0", err_cnt, 0);
        chk("rst_id0", id_out, 0);
        chk("rst_wd0", write_data, 0);
        repeat (3) @(posedge sys_clk);
        #1 rst = 1'b0;
        tick();
        chk("sizes", {write_size, read_size}, {10'd256, 10'd256});
        run_seq(8'hBC, EXP_ID, PB, 1'b0, 1'b0, 1'b0, 1'b0);
        run_seq(8'($urandom), 24'h000000, PB, 1'b0, 1'b0, 1'b0, 1'b0);
        run_seq(8'($urandom), EXP_ID, PB, 1'b1, 1'b1, 1'b0, 1'b0);
        run_seq(8'($urandom), EXP_ID, 200, 1'b0, 1'b0, 1'b0, 1'b0);
        run_seq(8'($urandom), EXP_ID, PB, 1'b0, 1'b0, 1'b1, 1'b0);
        run_seq(8'($urandom), EXP_ID, PB, 1'b0, 1'b0, 1'b0, 1'b1);
        run_seq(8'($urandom), EXP_ID, PB, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int r = 0; r < 3; r++) begin
            run_seq(8'($urandom), EXP_ID,
                    ($urandom_range(0, 1) != 0) ? PB : $urandom_range(1, 255),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    1'b0, 1'b0);
        end
        chk("req_onehot", hot_viol, 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
